irq_scheduler: RTL

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_arbiter.sv | 31 +++
 rtl/irq_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler.
// Arbitration mode is selected by IRQ_ROUND_ROBIN_EN (see irq_scheduler.sv).
package irq_pkg;

   localparam int IRQ_NUM_SRC   = 4;
   localparam int IRQ_VEC_W     = 6;
   localparam int IRQ_ISR_SHIFT = 4;
   localparam int IRQ_ID_W      = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   function automatic logic [IRQ_NUM_SRC-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
      id_onehot = {{(IRQ_NUM_SRC-1){1'b0}}, 1'b1} << id;
   endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational arbiter: searches req starting just after ptr and returns the first hit.
// Tying ptr to 3 turns it into a lowest-index-wins priority encoder.
module irq_arbiter
   import irq_pkg::*;
(
   input  logic [IRQ_NUM_SRC-1:0] req,
   input  logic [IRQ_ID_W-1:0]    ptr,
   output logic [IRQ_ID_W-1:0]    grant_id,
   output logic                   grant_valid
);

   logic [IRQ_ID_W-1:0] idx_s;

   // rotating search; the index wraps naturally in IRQ_ID_W bits
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = {IRQ_ID_W{1'b0}};
      idx_s       = {IRQ_ID_W{1'b0}};
      for (int k = 0; k < IRQ_NUM_SRC; k++) begin
         idx_s = ptr + IRQ_ID_W'(k + 1);
         if (!grant_valid && req[idx_s]) begin
            grant_valid = 1'b1;
            grant_id    = idx_s;
         end else begin
            grant_valid = grant_valid;
            grant_id    = grant_id;
         end
      end
   end

endmodule

// File: rtl/irq_scheduler.sv
// Edge-triggered interrupt scheduler feeding a single CPU request line.
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module irq_scheduler
   import irq_pkg::*;
#(
   parameter int NUM_SRC   = IRQ_NUM_SRC,
   parameter int VEC_W     = IRQ_VEC_W,
   parameter int ISR_SHIFT = IRQ_ISR_SHIFT
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic                mask_we,
   input  logic [NUM_SRC-1:0]  mask_wd,
   output logic [NUM_SRC-1:0]  mask_rd,
   output logic                cpu_irq,
   input  logic                cpu_ack,
   input  logic                cpu_done,
   output logic [IRQ_ID_W-1:0] isr_id,
   output logic [VEC_W-1:0]    isr_addr,
   output logic [NUM_SRC-1:0]  pending,
   output logic                busy
);

   irq_state_e          state_q, state_d;
   logic [NUM_SRC-1:0]  src_q, src_prev_q;
   logic [NUM_SRC-1:0]  pending_q, pending_d;
   logic [NUM_SRC-1:0]  mask_q;
   logic [NUM_SRC-1:0]  rise_s, clr_s, req_s;
   logic [IRQ_ID_W-1:0] isr_id_q, isr_id_d;
   logic [IRQ_ID_W-1:0] grant_id_s, rr_ptr_s;
   logic                grant_valid_s, ack_s;
   logic                cpu_irq_q, cpu_irq_d;
   logic                busy_q, busy_d;

   assign ack_s  = (state_q == REQ) && cpu_ack;
   assign rise_s = src_q & ~src_prev_q;
   assign clr_s  = ack_s ? id_onehot(isr_id_q) : {NUM_SRC{1'b0}};
   assign req_s  = pending_q & mask_q;
   // OR-ing the set after the clear lets a fresh edge survive a same-cycle ack
   assign pending_d = (pending_q & ~clr_s) | rise_s;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [IRQ_ID_W-1:0] rr_ptr_q;

   // last-granted pointer, advanced when the core takes the interrupt
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rr_ptr_q <= 2'd3;
      end else if (ack_s) begin
         rr_ptr_q <= isr_id_q;
      end else begin
         rr_ptr_q <= rr_ptr_q;
      end
   end

   assign rr_ptr_s = rr_ptr_q;
`else
   assign rr_ptr_s = 2'd3;
`endif

   irq_arbiter u_arbiter (
      .req         (req_s),
      .ptr         (rr_ptr_s),
      .grant_id    (grant_id_s),
      .grant_valid (grant_valid_s)
   );

   // next-state and registered-output decode
   always_comb begin
      state_d  = state_q;
      isr_id_d = isr_id_q;
      case (state_q)
         IDLE: begin
            if (grant_valid_s) begin
               state_d  = REQ;
               isr_id_d = grant_id_s;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (cpu_ack) begin
               state_d = SERVICE;
            end else begin
               state_d = REQ;
            end
         end
         SERVICE: begin
            if (cpu_done) begin
               state_d = IDLE;
            end else begin
               state_d = SERVICE;
            end
         end
         default: state_d = IDLE;
      endcase
      cpu_irq_d = (state_d == REQ);
      busy_d    = (state_d != IDLE);
   end

   // state, edge detect, pending and mask registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         src_q      <= {NUM_SRC{1'b0}};
         src_prev_q <= {NUM_SRC{1'b0}};
         pending_q  <= {NUM_SRC{1'b0}};
         mask_q     <= {NUM_SRC{1'b1}};
         isr_id_q   <= {IRQ_ID_W{1'b0}};
         cpu_irq_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= irq_src;
         src_prev_q <= src_q;
         pending_q  <= pending_d;
         isr_id_q   <= isr_id_d;
         cpu_irq_q  <= cpu_irq_d;
         busy_q     <= busy_d;
         if (mask_we) begin
            mask_q <= mask_wd;
         end else begin
            mask_q <= mask_q;
         end
      end
   end

   assign mask_rd  = mask_q;
   assign pending  = pending_q;
   assign cpu_irq  = cpu_irq_q;
   assign busy     = busy_q;
   assign isr_id   = isr_id_q;
   assign isr_addr = VEC_W'({isr_id_q, {ISR_SHIFT{1'b0}}});

endmodule
